// File: rtl/serial_addsub_pkg.sv
// Shared calculator definitions: sequencer state encoding and operation codes.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between the calculator front end and the serial add/sub sequencer.
interface serial_addsub_if #(parameter int WIDTH = 8);

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op_sub, a_in, b_in,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op_sub, a_in, b_in,
    output busy, done, result, carry_out, overflow
  );

endinterface

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder stage of the calculator; complement1_sel qualifies the operand bits,
// and finished flags that the stage is idle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic complement1_sel,
  output logic sum,
  output logic co,
  output logic finished
);

  assign sum      = complement1_sel & (a ^ b ^ ci);
  assign co       = complement1_sel & ((a & b) | (ci & (a ^ b)));
  assign finished = ~complement1_sel;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract sequencer: streams operands LSB-first through one full_adder,
// keeping the carry in a flip-flop, and reports result/carry/overflow with a done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_carryOut;
  logic             r_overflow;
  logic             w_shift;
  logic             w_last;
  logic             w_sum;
  logic             w_co;

  assign w_shift = (r_state == SHIFT);
  assign w_last  = w_shift && (r_cnt == LAST);

  full_adder u_fa (
    .a               (r_sa[0]),
    .b               (r_sb[0]),
    .ci              (r_carry),
    .complement1_sel (w_shift),
    .sum             (w_sum),
    .co              (w_co),
    .finished        ()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at load and the carry FF seeds the +1.
  // On the last bit the carry FF still holds the MSB carry-in, which gives signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_sa    <= bus.a_in;
      r_sb    <= (bus.op_sub == OP_SUB) ? ~bus.b_in : bus.b_in;
      r_carry <= bus.op_sub;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_sr    <= {w_sum, r_sr[WIDTH-1:1]};
      r_carry <= w_co;
      if (w_last) begin
        r_result   <= {w_sum, r_sr[WIDTH-1:1]};
        r_carryOut <= w_co;
        r_overflow <= r_carry ^ w_co;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_carryOut;
  assign bus.overflow  = r_overflow;

endmodule
